// File: rtl/payload_buffer_arbiter.sv
// Shares the single-port payload RAM between the packet engine (A) and the CPU (B) using a sticky owner with a bounded hold.
// Define PAYLOAD_ARB_STATS_EN to add the per-port stall counters and their stats_clear input.
module payload_buffer_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 16,
   parameter int BE_W     = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [BE_W-1:0]   a_byteenable,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_writedata,
   output logic              a_waitrequest,
   output logic              a_readdatavalid,
   output logic [DATA_W-1:0] a_readdata,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [BE_W-1:0]   b_byteenable,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_writedata,
   output logic              b_waitrequest,
   output logic              b_readdatavalid,
   output logic [DATA_W-1:0] b_readdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
`ifdef PAYLOAD_ARB_STATS_EN
   ,
   input  logic              stats_clear,
   output logic [15:0]       a_stall_cnt,
   output logic [15:0]       b_stall_cnt
`endif
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   logic              req_a;
   logic              req_b;
   logic              grant_a;
   logic              grant_b;
   logic              owner_keeps;
   logic              owner;
   logic [HOLD_W-1:0] hold_cnt;

   assign req_a       = a_read | a_write;
   assign req_b       = b_read | b_write;
   assign owner_keeps = (hold_cnt < HOLD_MAX);

   // On a tie the owner wins until its hold budget is spent, then the other port takes over.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (req_a && req_b) begin
         if ((owner == OWNER_A) == owner_keeps) grant_a = 1'b1;
         else                                   grant_b = 1'b1;
      end else begin
         grant_a = req_a;
         grant_b = req_b;
      end
   end

   assign a_waitrequest = req_a & ~grant_a;
   assign b_waitrequest = req_b & ~grant_b;

   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_write      = 1'b0;
      ram_writedata  = '0;
      if (grant_a) begin
         ram_address    = a_address;
         ram_byteenable = a_byteenable;
         ram_write      = a_write;
         ram_writedata  = a_writedata;
      end else if (grant_b) begin
         ram_address    = b_address;
         ram_byteenable = b_byteenable;
         ram_write      = b_write;
         ram_writedata  = b_writedata;
      end
   end

   assign ram_chipselect = grant_a | grant_b;
   assign ram_clken      = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner    <= OWNER_A;
         hold_cnt <= '0;
      end else if (grant_a || grant_b) begin
         if (grant_b != owner) begin
            owner    <= grant_b;
            hold_cnt <= HOLD_W'(1);
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   // ---- stage p1: RAM q is valid one cycle after the registered address ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_readdatavalid <= 1'b0;
         b_readdatavalid <= 1'b0;
      end else begin
         a_readdatavalid <= grant_a & a_read & ~a_write;
         b_readdatavalid <= grant_b & b_read & ~b_write;
      end
   end

   assign a_readdata = ram_readdata;
   assign b_readdata = ram_readdata;

`ifdef PAYLOAD_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
      if (inc && cnt != 16'hFFFF) return cnt + 16'd1;
      return cnt;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_stall_cnt <= '0;
         b_stall_cnt <= '0;
      end else if (stats_clear) begin
         a_stall_cnt <= '0;
         b_stall_cnt <= '0;
      end else begin
         a_stall_cnt <= sat_inc(a_stall_cnt, a_waitrequest);
         b_stall_cnt <= sat_inc(b_stall_cnt, b_waitrequest);
      end
   end
`endif

endmodule

// File: tb/tb_payload_buffer_arbiter.sv
// Scoreboard bench for payload_buffer_arbiter with a behavioural single-port RAM (registered address, unregistered q).
module tb_payload_buffer_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] a_address, b_address;
   logic [BE_W-1:0]   a_byteenable, b_byteenable;
   logic              a_read, a_write, b_read, b_write;
   logic [DATA_W-1:0] a_writedata, b_writedata;
   logic              a_waitrequest, b_waitrequest;
   logic              a_readdatavalid, b_readdatavalid;
   logic [DATA_W-1:0] a_readdata, b_readdata;
   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [DATA_W-1:0] ram_writedata, ram_readdata;
`ifdef PAYLOAD_ARB_STATS_EN
   logic              stats_clear = 1'b0;
   logic [15:0]       a_stall_cnt, b_stall_cnt;
`endif

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic ga;

   payload_buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
      .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdatavalid(a_readdatavalid),
      .a_readdata(a_readdata),
      .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
      .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdatavalid(b_readdatavalid),
      .b_readdata(b_readdata),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
      .ram_readdata(ram_readdata)
`ifdef PAYLOAD_ARB_STATS_EN
      , .stats_clear(stats_clear), .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 8192x16 RAM: byte-enabled write, registered address, combinational q.
   logic [15:0]       mem [0:8191];
   logic [ADDR_W-1:0] ram_areg = '0;
   always @(posedge clk) begin
      if (ram_clken) begin
         if (ram_chipselect && ram_write) begin
            if (ram_byteenable[0]) mem[ram_address][7:0]  <= ram_writedata[7:0];
            if (ram_byteenable[1]) mem[ram_address][15:8] <= ram_writedata[15:8];
         end
         ram_areg <= ram_address;
      end
   end
   assign ram_readdata = mem[ram_areg];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic rd, input logic wr, input logic [ADDR_W-1:0] ad,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
      a_read = rd; a_write = wr; a_address = ad; a_byteenable = be; a_writedata = wd;
   endtask

   task automatic drv_b(input logic rd, input logic wr, input logic [ADDR_W-1:0] ad,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
      b_read = rd; b_write = wr; b_address = ad; b_byteenable = be; b_writedata = wd;
   endtask

   task automatic idle();
      drv_a(1'b0, 1'b0, '0, '0, '0);
      drv_b(1'b0, 1'b0, '0, '0, '0);
   endtask

   // Monitor: every readdatavalid pops the next expected word and its expected cycle.
   always @(negedge clk) begin
      if (a_readdatavalid) begin
         if (qa.size() == 0) chk("a_unexpected_rdv", 32'(a_readdatavalid), 32'd0);
         else begin
            ea = qa.pop_front();
            chk("a_readdata", 32'(a_readdata), 32'(ea.d));
            chk("a_rdv_cycle", 32'(cyc), 32'(ea.c));
         end
      end
      if (b_readdatavalid) begin
         if (qb.size() == 0) chk("b_unexpected_rdv", 32'(b_readdatavalid), 32'd0);
         else begin
            eb = qb.pop_front();
            chk("b_readdata", 32'(b_readdata), 32'(eb.d));
            chk("b_rdv_cycle", 32'(cyc), 32'(eb.c));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      idle();
      repeat (2) tick();
      chk("rst_a_rdv", 32'(a_readdatavalid), 32'd0);
      chk("rst_b_rdv", 32'(b_readdatavalid), 32'd0);
      chk("rst_cs", 32'(ram_chipselect), 32'd0);
      chk("rst_clken", 32'(ram_clken), 32'd1);
      reset = 1'b0;

      // Contention: grant pattern AAAABBBB... with MAX_HOLD=4
      for (int i = 0; i < 20; i++) begin
         drv_a(1'b0, 1'b1, ADDR_W'(16'h0100 + i), 2'b11, DATA_W'(16'hA000 + i));
         drv_b(1'b0, 1'b1, ADDR_W'(16'h0200 + i), 2'b11, DATA_W'(16'hB000 + i));
         #2;
         ga = ((i / 4) % 2) == 0;
         chk("tie_a_wait", 32'(a_waitrequest), 32'(!ga));
         chk("tie_b_wait", 32'(b_waitrequest), 32'(ga));
         chk("tie_ram_addr", 32'(ram_address), ga ? 32'(16'h0100 + i) : 32'(16'h0200 + i));
         chk("tie_ram_wdata", 32'(ram_writedata), ga ? 32'(16'hA000 + i) : 32'(16'hB000 + i));
         tick();
      end
      idle();
      #2;
      chk("idle_cs", 32'(ram_chipselect), 32'd0);
      chk("idle_addr", 32'(ram_address), 32'd0);
      chk("idle_write", 32'(ram_write), 32'd0);
`ifdef PAYLOAD_ARB_STATS_EN
      chk("a_stall_cnt", 32'(a_stall_cnt), 32'd8);
      chk("b_stall_cnt", 32'(b_stall_cnt), 32'd12);
      drv_a(1'b0, 1'b1, 13'h0100, 2'b11, 16'h0000);
      drv_b(1'b0, 1'b1, 13'h0200, 2'b11, 16'h0000);
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
      idle();
      #2;
      chk("a_stall_clr", 32'(a_stall_cnt), 32'd0);
      chk("b_stall_clr", 32'(b_stall_cnt), 32'd0);
`endif
      tick();

      // A writes then reads back 0x0123
      drv_a(1'b0, 1'b1, 13'h0123, 2'b11, 16'hBEEF);
      #2;
      chk("a_wr_wait", 32'(a_waitrequest), 32'd0);
      chk("a_wr_be", 32'(ram_byteenable), 32'd3);
      tick();
      drv_a(1'b1, 1'b0, 13'h0123, 2'b11, 16'h0000);
      qa.push_back('{d: 16'hBEEF, c: cyc + 1});
      #2;
      chk("a_rd_write", 32'(ram_write), 32'd0);
      tick();
      idle();
      tick();

      // Partial write merge through B
      drv_a(1'b0, 1'b1, 13'h1FFF, 2'b11, 16'h1234);
      tick();
      idle();
      drv_b(1'b0, 1'b1, 13'h1FFF, 2'b10, 16'hAB00);
      #2;
      chk("b_wr_be", 32'(ram_byteenable), 32'd2);
      tick();
      drv_b(1'b1, 1'b0, 13'h1FFF, 2'b11, 16'h0000);
      qb.push_back('{d: 16'hAB34, c: cyc + 1});
      #2;
      chk("b_rd_wait", 32'(b_waitrequest), 32'd0);
      tick();
      idle();

      // Alternating A/B reads return in order without bubbles
      for (int k = 0; k < 4; k++) begin
         idle();
         if (k % 2 == 0) begin
            drv_a(1'b1, 1'b0, 13'h0123, 2'b11, 16'h0000);
            qa.push_back('{d: 16'hBEEF, c: cyc + 1});
         end else begin
            drv_b(1'b1, 1'b0, 13'h1FFF, 2'b11, 16'h0000);
            qb.push_back('{d: 16'hAB34, c: cyc + 1});
         end
         tick();
      end
      idle();

      // Read+write together is a write and returns nothing
      drv_a(1'b1, 1'b1, 13'h0050, 2'b11, 16'h7777);
      #2;
      chk("rw_is_write", 32'(ram_write), 32'd1);
      tick();
      drv_a(1'b1, 1'b0, 13'h0050, 2'b11, 16'h0000);
      qa.push_back('{d: 16'h7777, c: cyc + 1});
      tick();
      idle();

      // B streams reads 0..9 while A is idle
      for (int i = 0; i < 10; i++) begin
         drv_a(1'b0, 1'b1, ADDR_W'(i), 2'b11, DATA_W'(16'h5000 + i));
         tick();
      end
      idle();
      for (int i = 0; i < 10; i++) begin
         drv_b(1'b1, 1'b0, ADDR_W'(i), 2'b11, 16'h0000);
         qb.push_back('{d: DATA_W'(16'h5000 + i), c: cyc + 1});
         #2;
         chk("b_stream_wait", 32'(b_waitrequest), 32'd0);
         tick();
      end
      idle();
      tick();

      // Reset during a read: no valid, owner back to A
      drv_b(1'b0, 1'b1, 13'h0300, 2'b11, 16'h0F0F);
      tick();
      idle();
      drv_a(1'b1, 1'b0, 13'h0123, 2'b11, 16'h0000);
      #2;
      reset = 1'b1;
      tick();
      idle();
      chk("rst_rd_no_rdv0", 32'(a_readdatavalid), 32'd0);
      tick();
      chk("rst_rd_no_rdv1", 32'(a_readdatavalid), 32'd0);
      reset = 1'b0;
      drv_a(1'b0, 1'b1, 13'h0400, 2'b11, 16'h1111);
      drv_b(1'b0, 1'b1, 13'h0500, 2'b11, 16'h2222);
      #2;
      chk("post_rst_a_wait", 32'(a_waitrequest), 32'd0);
      chk("post_rst_b_wait", 32'(b_waitrequest), 32'd1);
      tick();
      idle();
      repeat (3) tick();
      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
